// File: rtl/core_pkg.sv
// Shared definitions for the core memory subsystem: bus widths, the
// arbiter state encoding and the full-word byte-enable constant.
package core_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Last grant decision; held for exactly one cycle to steer the response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IF   = 2'd1,
    ST_DM   = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_t;

  // A word access is misaligned when either low byte-address bit is set.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter of consecutive cycles in which fetch was denied.
// Clear has priority over increment; at_max flags the saturation value.
module starve_counter #(
  parameter int MAX = 4,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic          at_max
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt;

  assign at_max = (cnt == MAX_C);

  // Count denied fetch cycles, holding at MAX until fetch is served or leaves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store
// (DM). DM wins conflicts unless IF has been denied STARVE_MAX cycles in a
// row. Grants and the memory drive are combinational; responses come back
// one cycle later from a registered state plus registered read data.
module mem_arbiter #(
  parameter int ADDR_W     = core_pkg::ADDR_W,
  parameter int DATA_W     = core_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  import core_pkg::*;

  arb_state_t state;
  arb_state_t state_nxt;
  logic       starve_max;
  logic       dm_mis;
  logic       dm_ok;
  logic       unused_if_lo;

  // Fetch ignores the byte offset: it always reads the enclosing word.
  assign unused_if_lo = ^if_addr[1:0];

  // Arbitration: DM by default, IF when alone or when it has starved long enough.
  assign if_gnt = if_req && (!dm_req || starve_max);
  assign dm_gnt = dm_req && !if_gnt;
  assign dm_mis = is_misaligned(dm_addr[1:0]);
  assign dm_ok  = dm_gnt && !dm_mis;

  // Memory drive: a misaligned DM grant is consumed without touching memory.
  assign mem_en    = if_gnt || dm_ok;
  assign mem_we    = dm_ok && dm_we;
  assign mem_be    = dm_ok ? (dm_be & BE_WORD) : 4'b0000;
  assign mem_addr  = dm_gnt ? dm_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
  assign mem_wdata = dm_wdata;

  // Next state is simply this cycle's grant decision.
  always_comb begin
    state_nxt = ST_IDLE;
    if (if_gnt) begin
      state_nxt = ST_IF;
    end else if (dm_gnt) begin
      state_nxt = dm_mis ? ST_ERR : ST_DM;
    end
  end

  // Denied fetch cycles accumulate; any fetch grant or idle fetch port resets.
  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (if_req && !if_gnt),
    .clr    (!if_req || if_gnt),
    .at_max (starve_max)
  );

  // Grant edge: record the grant and capture read data for its requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (if_gnt) begin
        if_rdata <= mem_rdata;
      end
      if (dm_gnt) begin
        dm_rdata <= (dm_mis || dm_we) ? '0 : mem_rdata;
      end
    end
  end

  // Response strobes decode the one-cycle-old grant held in the state flop.
  assign if_valid = (state == ST_IF);
  assign dm_valid = (state == ST_DM) || (state == ST_ERR);
  assign dm_err   = (state == ST_ERR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a word memory with combinational read sits on the
// memory port, and a transaction-level model predicts grants, memory drive
// and the one-cycle-late responses for directed and random traffic.
module tb_mem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_be;
  logic          dm_gnt;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;
  logic          dm_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_gnt    (dm_gnt),
    .dm_valid  (dm_valid),
    .dm_rdata  (dm_rdata),
    .dm_err    (dm_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  // Memory array on the DUT side
  logic [DW-1:0] mem     [0:63];
  // Model's view of the same memory, updated only from predicted stores
  logic [DW-1:0] ref_mem [0:63];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign mem_rdata = mem[mem_addr];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Model state: consecutive IF denials and the responses due this cycle
  int            m_starve;
  logic          cur_if_valid, cur_dm_valid, cur_dm_err;
  logic [DW-1:0] cur_if_rdata, cur_dm_rdata;
  logic          last_if_gnt, last_dm_gnt;
  logic [9:0]    glog;

  function automatic logic [DW-1:0] pat(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // One clock: check everything at the falling edge, advance the model,
  // return just after the rising edge so the caller can drive the next cycle.
  task automatic cycle();
    logic          e_if, e_dm, mis, e_en, e_ok;
    logic [AW-3:0] e_addr;
    logic          n_if_valid, n_dm_valid, n_dm_err;
    logic [DW-1:0] n_if_rdata, n_dm_rdata;
    @(negedge clk);
    e_if = if_req && (!dm_req || m_starve >= SMAX);
    e_dm = dm_req && !e_if;
    mis  = (dm_addr[1:0] != 2'b00);
    e_ok = e_dm && !mis;
    e_en = e_if || e_ok;
    e_addr = e_dm ? dm_addr[AW-1:2] : if_addr[AW-1:2];
    chk("if_gnt", if_gnt, e_if);
    chk("dm_gnt", dm_gnt, e_dm);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_ok && dm_we);
    chk("mem_be", mem_be, e_ok ? dm_be : 4'h0);
    chk("mem_wdata", mem_wdata, dm_wdata);
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    chk("if_valid", if_valid, cur_if_valid);
    chk("if_rdata", if_rdata, cur_if_rdata);
    chk("dm_valid", dm_valid, cur_dm_valid);
    chk("dm_err", dm_err, cur_dm_err);
    chk("dm_rdata", dm_rdata, cur_dm_rdata);
    n_if_valid = e_if;
    n_if_rdata = e_if ? ref_mem[if_addr[AW-1:2]] : cur_if_rdata;
    n_dm_valid = e_dm;
    n_dm_err   = e_dm && mis;
    n_dm_rdata = e_dm ? ((mis || dm_we) ? 32'h0 : ref_mem[dm_addr[AW-1:2]]) : cur_dm_rdata;
    if (e_ok && dm_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_be[b]) ref_mem[dm_addr[AW-1:2]][8*b +: 8] = dm_wdata[8*b +: 8];
      end
    end
    if (if_req && !e_if) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
    else m_starve = 0;
    last_if_gnt = if_gnt;
    last_dm_gnt = dm_gnt;
    glog = {glog[8:0], if_gnt};
    @(posedge clk);
    #1;
    cur_if_valid = n_if_valid;
    cur_if_rdata = n_if_rdata;
    cur_dm_valid = n_dm_valid;
    cur_dm_err   = n_dm_err;
    cur_dm_rdata = n_dm_rdata;
  endtask

  // Assert reset from wherever we are, hold across two edges, then release.
  task automatic do_reset();
    rst    = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    cur_if_valid = 1'b0;
    cur_dm_valid = 1'b0;
    cur_dm_err   = 1'b0;
    cur_if_rdata = '0;
    cur_dm_rdata = '0;
    m_starve     = 0;
    last_if_gnt  = 1'b0;
    last_dm_gnt  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_dm_valid", dm_valid, 1'b0);
    chk("rst_dm_err", dm_err, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_starve", 32'(dut.u_starve.cnt), 32'h0);
    rst = 1'b1;
  endtask

  task automatic fetch_three();
    for (int k = 0; k < 3; k++) begin
      if_req  = 1'b1;
      if_addr = 8'(4 * k);
      cycle();
      chk("s1_if_valid", if_valid, 1'b1);
      chk("s1_word", if_rdata, ref_mem[k]);
      chk("s1_dm_valid", dm_valid, 1'b0);
    end
    if_req = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    glog = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = pat(i);
      ref_mem[i] = pat(i);
    end
    do_reset();

    // IF-only stream
    fetch_three();

    // DM store then load of the same word
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h08; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF;
    cycle();
    chk("st_ack_valid", dm_valid, 1'b1);
    chk("st_ack_rdata", dm_rdata, 32'h0);
    dm_we = 1'b0; dm_wdata = 32'h0;
    cycle();
    chk("ld_valid", dm_valid, 1'b1);
    chk("ld_deadbeef", dm_rdata, 32'hDEADBEEF);
    dm_req = 1'b0;
    cycle();

    // Sustained conflict: IF must break through every fifth cycle
    if_req = 1'b1; if_addr = 8'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h20;
    glog = '0;
    repeat (10) cycle();
    chk("starve_seq", 32'(glog), 32'(10'b0000100001));
    if_req = 1'b0; dm_req = 1'b0;
    cycle();

    // Misaligned load, then misaligned store that must not write memory
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h06;
    cycle();
    chk("mis_ld_valid", dm_valid, 1'b1);
    chk("mis_ld_err", dm_err, 1'b1);
    dm_we = 1'b1; dm_addr = 8'h09; dm_wdata = 32'h1234_5678; dm_be = 4'hF;
    cycle();
    chk("mis_st_err", dm_err, 1'b1);
    dm_we = 1'b0; dm_addr = 8'h08;
    cycle();
    chk("mis_st_nowrite", dm_rdata, 32'hDEADBEEF);
    chk("mis_clear_err", dm_err, 1'b0);
    dm_req = 1'b0;
    cycle();

    // Reset while an IF grant is in flight
    if_req = 1'b1; if_addr = 8'h00;
    @(negedge clk);
    #1;
    chk("mid_if_gnt", if_gnt, 1'b1);
    do_reset();
    cycle();
    chk("post_rst_no_valid", if_valid, 1'b0);
    fetch_three();

    // Idle
    repeat (5) cycle();
    chk("idle_starve", 32'(dut.u_starve.cnt), 32'h0);

    // Random traffic obeying the hold-until-grant rule
    for (int i = 0; i < 500; i++) begin
      if (!if_req || last_if_gnt) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (!dm_req || last_dm_gnt) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = $urandom_range(0, 1) != 0;
        dm_addr  = {6'($urandom), (($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00)};
        dm_wdata = $urandom;
        dm_be    = 4'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        dm_req = 1'b0;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
